// File: rtl/hitreg_seq_ctrl.sv
// hitreg_seq_ctrl: per-event load/settle/evaluate/present/advance/flush sequencer for the hit register bank.
module hitreg_seq_ctrl #(
    parameter int         SETTLE_CYC = 2,
    parameter logic [5:0] REQ_MASK   = 6'h3F,
    parameter int         MAX_COMB   = 4096,
    parameter int         CW         = 13
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_we,
    input  logic          in_ee,
    output logic          in_hold,
    output logic          hr_we,
    output logic          hr_gnext,
    output logic          hr_clear,
    output logic          hr_reset,
    input  logic [5:0]    hr_empty,
    input  logic [5:0]    hr_overflow,
    input  logic          hr_glast,
    input  logic          hr_out_of_order,
    output logic          fit_valid,
    output logic          fit_last,
    input  logic          fit_ready,
    output logic          ev_done,
    output logic [3:0]    ev_status,
    output logic [CW-1:0] ev_ncomb
);
    localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
    localparam logic [2:0] LOAD    = 3'd0;
    localparam logic [2:0] SETTLE  = 3'd1;
    localparam logic [2:0] EVAL    = 3'd2;
    localparam logic [2:0] PRESENT = 3'd3;
    localparam logic [2:0] ADVANCE = 3'd4;
    localparam logic [2:0] FLUSH   = 3'd5;

    logic [2:0]    state, state_n;
    logic [SW-1:0] cnt;
    logic [CW-1:0] ncomb;
    logic          last_q, trunc, ooo, ovf, no_comb;
    logic          accept, full, err, missing;

    assign accept    = state == PRESENT && fit_ready;
    assign full      = ncomb + CW'(1) == CW'(MAX_COMB);
    assign err       = ooo | ovf;
    assign missing   = (hr_empty & REQ_MASK) != 6'd0;
    assign in_hold   = state != LOAD;
    assign hr_we     = in_we && state == LOAD;
    assign hr_gnext  = state == ADVANCE;
    assign hr_clear  = state == FLUSH;
    assign hr_reset  = reset | hr_clear;
    assign fit_valid = state == PRESENT;
    assign fit_last  = fit_valid & last_q;
    assign ev_done   = hr_clear;
    assign ev_status = ev_done ? {trunc, ooo, ovf, no_comb} : 4'd0;
    assign ev_ncomb  = ev_done ? ncomb : '0;

    always_comb begin
        state_n = state;
        case (state)
            LOAD:    state_n = in_ee ? SETTLE : LOAD;
            SETTLE:  state_n = cnt == '0 ? EVAL : SETTLE;
            EVAL:    state_n = err || missing ? FLUSH : PRESENT;
            PRESENT: state_n = !fit_ready ? PRESENT : (last_q || full) ? FLUSH : ADVANCE;
            ADVANCE: state_n = SETTLE;
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= LOAD;
            cnt     <= '0;
            ncomb   <= '0;
            last_q  <= 1'b0;
            trunc   <= 1'b0;
            ooo     <= 1'b0;
            ovf     <= 1'b0;
            no_comb <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= state == SETTLE ? cnt - SW'(1) : SW'(SETTLE_CYC - 1);
            if (state == EVAL)
                last_q <= hr_glast;
            if (state == FLUSH) begin
                ncomb   <= '0;
                trunc   <= 1'b0;
                ooo     <= 1'b0;
                ovf     <= 1'b0;
                no_comb <= 1'b0;
            end else begin
                if (accept && ncomb != CW'(MAX_COMB))
                    ncomb <= ncomb + CW'(1);
                if (accept && !last_q && full)
                    trunc <= 1'b1;
                if (state == LOAD && hr_out_of_order)
                    ooo <= 1'b1;
                // a word offered while holding is lost, so the event is reported as overflowed
                if ((state == LOAD && |hr_overflow) || (in_we && in_hold))
                    ovf <= 1'b1;
                if (state == EVAL && !err && missing)
                    no_comb <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hitreg_seq_ctrl.sv
// tb_hitreg_seq_ctrl: table-driven and directed sequence checks of hitreg_seq_ctrl with a behavioural bank model.
module tb_hitreg_seq_ctrl;
    logic        clock = 1'b0, reset = 1'b1;
    logic        in_we = 1'b0, in_ee = 1'b0, fit_ready = 1'b1;
    logic [5:0]  hr_empty = 6'd0, hr_overflow = 6'd0;
    logic        hr_out_of_order = 1'b0;
    logic        in_hold, hr_we, hr_gnext, hr_clear, hr_reset, fit_valid, fit_last, ev_done;
    logic [3:0]  ev_status;
    logic [12:0] ev_ncomb;
    logic        hold4, we4, gn4, clr4, rst4, fv4, fl4, done4;
    logic [3:0]  st4;
    logic [2:0]  nc4;
    int          nt = 1, gc0 = 0, gc4 = 0;
    logic        glast0, glast4;
    logic [11:0] obs;
    int          total = 0, bad = 0;

    always #5 clock = ~clock;

    assign glast0 = gc0 == nt - 1;
    assign glast4 = gc4 == nt - 1;
    assign obs = {in_hold, hr_we, hr_gnext, hr_clear, hr_reset, fit_valid, fit_last, ev_done, ev_status};

    always_ff @(posedge clock) begin
        gc0 <= hr_reset ? 0 : gc0 + (hr_gnext ? 1 : 0);
        gc4 <= rst4 ? 0 : gc4 + (gn4 ? 1 : 0);
    end

    hitreg_seq_ctrl dut (
        .clock(clock), .reset(reset), .in_we(in_we), .in_ee(in_ee), .in_hold(in_hold),
        .hr_we(hr_we), .hr_gnext(hr_gnext), .hr_clear(hr_clear), .hr_reset(hr_reset),
        .hr_empty(hr_empty), .hr_overflow(hr_overflow), .hr_glast(glast0),
        .hr_out_of_order(hr_out_of_order), .fit_valid(fit_valid), .fit_last(fit_last),
        .fit_ready(fit_ready), .ev_done(ev_done), .ev_status(ev_status), .ev_ncomb(ev_ncomb)
    );

    hitreg_seq_ctrl #(.MAX_COMB(4), .CW(3)) dut4 (
        .clock(clock), .reset(reset), .in_we(in_we), .in_ee(in_ee), .in_hold(hold4),
        .hr_we(we4), .hr_gnext(gn4), .hr_clear(clr4), .hr_reset(rst4),
        .hr_empty(hr_empty), .hr_overflow(hr_overflow), .hr_glast(glast4),
        .hr_out_of_order(hr_out_of_order), .fit_valid(fv4), .fit_last(fl4),
        .fit_ready(fit_ready), .ev_done(done4), .ev_status(st4), .ev_ncomb(nc4)
    );

    typedef struct {
        logic [5:0]  emp;
        logic        ooo, we, ee;
        logic [11:0] exp;
        logic [12:0] nc;
    } vec_t;
    vec_t tbl[27];

    function automatic vec_t mk(logic [5:0] emp, logic ooo, logic we, logic ee, logic [11:0] exp, logic [12:0] nc);
        mk = '{emp, ooo, we, ee, exp, nc};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        int first, acc0, g0, lastcnt, lastidx, prev, gaps, dn0, ncv0, stv0;
        int acc4, last4c, dn4, ncv4, stv4, stall, dn;
        tbl[0]  = mk(6'h00, 0, 1, 0, 12'h400, 0);
        tbl[1]  = mk(6'h00, 0, 1, 1, 12'h400, 0);
        tbl[2]  = mk(6'h00, 0, 0, 0, 12'h800, 0);
        tbl[3]  = mk(6'h00, 0, 0, 0, 12'h800, 0);
        tbl[4]  = mk(6'h00, 0, 0, 0, 12'h800, 0);
        tbl[5]  = mk(6'h00, 0, 0, 0, 12'h860, 0);
        tbl[6]  = mk(6'h00, 0, 0, 0, 12'h990, 1);
        tbl[7]  = mk(6'h00, 0, 0, 0, 12'h000, 0);
        tbl[8]  = mk(6'h04, 0, 1, 1, 12'h400, 0);
        tbl[9]  = mk(6'h04, 0, 0, 0, 12'h800, 0);
        tbl[10] = mk(6'h04, 0, 0, 0, 12'h800, 0);
        tbl[11] = mk(6'h04, 0, 0, 0, 12'h800, 0);
        tbl[12] = mk(6'h04, 0, 0, 0, 12'h991, 0);
        tbl[13] = mk(6'h00, 0, 0, 0, 12'h000, 0);
        tbl[14] = mk(6'h00, 1, 1, 0, 12'h400, 0);
        tbl[15] = mk(6'h00, 0, 0, 1, 12'h000, 0);
        tbl[16] = mk(6'h00, 0, 0, 0, 12'h800, 0);
        tbl[17] = mk(6'h00, 0, 0, 0, 12'h800, 0);
        tbl[18] = mk(6'h00, 0, 0, 0, 12'h800, 0);
        tbl[19] = mk(6'h00, 0, 0, 0, 12'h994, 0);
        tbl[20] = mk(6'h00, 0, 0, 0, 12'h000, 0);
        tbl[21] = mk(6'h00, 0, 0, 1, 12'h000, 0);
        tbl[22] = mk(6'h00, 0, 1, 0, 12'h800, 0);
        tbl[23] = mk(6'h00, 0, 0, 0, 12'h800, 0);
        tbl[24] = mk(6'h00, 0, 0, 0, 12'h800, 0);
        tbl[25] = mk(6'h00, 0, 0, 0, 12'h992, 0);
        tbl[26] = mk(6'h00, 0, 0, 0, 12'h000, 0);

        #1 chk("reset_outputs", obs, 12'h080);
        chk("reset_ncomb", ev_ncomb, 0);
        @(negedge clock);
        @(negedge clock) reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            hr_empty = tbl[i].emp;
            hr_out_of_order = tbl[i].ooo;
            in_we = tbl[i].we;
            in_ee = tbl[i].ee;
            #1 chk($sformatf("row%0d_outs", i), obs, tbl[i].exp);
            chk($sformatf("row%0d_ncomb", i), ev_ncomb, tbl[i].nc);
            @(negedge clock);
        end
        in_we = 0; in_ee = 0; hr_empty = 0; hr_out_of_order = 0;

        nt = 8;
        first = -1; acc0 = 0; g0 = 0; lastcnt = 0; lastidx = 0; prev = -1; gaps = 0;
        dn0 = 0; ncv0 = 0; stv0 = 0; acc4 = 0; last4c = 0; dn4 = 0; ncv4 = 0; stv4 = 0;
        in_ee = 1;
        @(negedge clock) in_ee = 0;
        for (int c = 1; c <= 80; c++) begin
            if (fit_valid && first < 0) first = c;
            if (fit_valid && fit_ready) begin
                acc0++;
                if (fit_last) begin lastcnt++; lastidx = acc0; end
                if (prev >= 0 && c - prev != 5) gaps++;
                prev = c;
            end
            if (hr_gnext) g0++;
            if (ev_done) begin dn0++; ncv0 = int'(ev_ncomb); stv0 = int'(ev_status); end
            if (fv4 && fit_ready) acc4++;
            if (fl4) last4c++;
            if (done4) begin dn4++; ncv4 = int'(nc4); stv4 = int'(st4); end
            @(negedge clock);
        end
        chk("t2_first_latency", first, 4);
        chk("t2_fits", acc0, 8);
        chk("t2_gnext", g0, 7);
        chk("t2_last_count", lastcnt, 1);
        chk("t2_last_index", lastidx, 8);
        chk("t2_gap_errors", gaps, 0);
        chk("t2_done", dn0, 1);
        chk("t2_ncomb", ncv0, 8);
        chk("t2_status", stv0, 0);
        chk("t5_fits", acc4, 4);
        chk("t5_last", last4c, 0);
        chk("t5_done", dn4, 1);
        chk("t5_ncomb", ncv4, 4);
        chk("t5_status", stv4, 8);

        nt = 2;
        fit_ready = 0;
        in_ee = 1;
        @(negedge clock) in_ee = 0;
        for (int i = 0; i < 20 && !fit_valid; i++) @(negedge clock);
        chk("t4_valid", fit_valid, 1);
        stall = 0;
        for (int i = 0; i < 10; i++) begin
            if (!fit_valid || fit_last || hr_gnext || !in_hold) stall++;
            @(negedge clock);
        end
        chk("t4_stall_errors", stall, 0);
        fit_ready = 1;
        dn0 = 0; ncv0 = 0; stv0 = 0; g0 = 0;
        for (int i = 0; i < 30; i++) begin
            if (hr_gnext) g0++;
            if (ev_done) begin dn0++; ncv0 = int'(ev_ncomb); stv0 = int'(ev_status); end
            @(negedge clock);
        end
        chk("t4_done", dn0, 1);
        chk("t4_ncomb", ncv0, 2);
        chk("t4_status", stv0, 0);
        chk("t4_gnext", g0, 1);

        nt = 1;
        in_ee = 1;
        @(negedge clock) in_ee = 0;
        chk("t6_settle_hold", in_hold, 1);
        #2 reset = 1;
        #1 chk("t6_reset_outputs", obs, 12'h080);
        chk("t6_reset_hold4", hold4, 0);
        @(negedge clock) reset = 0;
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (ev_done || done4) dn++;
            @(negedge clock);
        end
        chk("t6_no_done", dn, 0);
        chk("t6_idle_outputs", obs, 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
